// File: rtl/crop_norm_writer.sv
// ============================================================================
// Module   : crop_norm_writer
// Purpose  : Captures an OUT_ROWS x OUT_COLS crop window from an 8-bit
//            raster-order AXI-Stream frame into an internal buffer and tracks
//            the window maximum. It publishes the maximum (0 becomes 1) as the
//            normalization denominator, then streams the buffered crop out.
//            Sequencing uses the ap_start/ap_ready/ap_idle/ap_done handshake.
// Ports    : clk, reset (sync, active-high)
//            ap_start / ap_ready / ap_idle / ap_done  block control
//            crop_row_start / crop_col_start            window origin (clamped)
//            s_axis_*                                   input frame slave
//            norm_denominator(_tvalid)                  window maximum
//            m_axis_*                                   cropped pixel master
// Options  : CROP_NORM_WRITER_SOF_EN - adds s_axis_tuser start-of-frame input
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crop_norm_writer #(
    parameter int IN_ROWS  = 32,
    parameter int IN_COLS  = 32,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_idle,
    output logic                       ap_done,
    input  logic [$clog2(IN_ROWS)-1:0] crop_row_start,
    input  logic [$clog2(IN_COLS)-1:0] crop_col_start,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [7:0]                 s_axis_tdata,
`ifdef CROP_NORM_WRITER_SOF_EN
    input  logic                       s_axis_tuser,
`endif
    output logic [7:0]                 norm_denominator,
    output logic                       norm_denominator_tvalid,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tlast
);

    localparam int c_RW    = $clog2(IN_ROWS);
    localparam int c_CW    = $clog2(IN_COLS);
    localparam int c_DEPTH = OUT_ROWS * OUT_COLS;
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_PUBLISH = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_idle;
    logic            r_done;
    logic            r_s_ready;
    logic [c_RW-1:0] r_row;
    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row0;
    logic [c_CW-1:0] r_col0;
    logic [7:0]      r_max;
    logic [7:0]      r_denom;
    logic            r_denom_valid;

    // Read pipeline: address/issue -> P stage (RAM output) -> M stage (port)
    logic [c_AW-1:0] r_rd_addr;
    logic            r_rd_more;
    logic            r_p_valid;
    logic            r_p_last;
    logic            r_m_valid;
    logic            r_m_last;
    logic [7:0]      r_m_data;

    logic [7:0]      r_mem [c_DEPTH];
    logic [7:0]      r_q;

    // ------------------------------------------------------------------
    // Capture-side position decode
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_active;
    logic [c_RW-1:0] w_row;
    logic [c_CW-1:0] w_col;
    logic [7:0]      w_max_base;
    int              w_rrel;
    int              w_crel;
    logic            w_in_win;
    logic [c_AW-1:0] w_wr_addr;
    logic            w_wr_en;
    logic            w_col_wrap;
    logic            w_last_in;
    logic [c_RW-1:0] w_next_row;
    logic [c_CW-1:0] w_next_col;
    logic [7:0]      w_next_max;
    logic [c_RW-1:0] w_row0_clamp;
    logic [c_CW-1:0] w_col0_clamp;

    assign w_accept = r_s_ready && s_axis_tvalid;

`ifdef CROP_NORM_WRITER_SOF_EN
    logic r_sof_seen;
    // A tuser beat is always pixel (0,0) and restarts the running max.
    assign w_active   = r_sof_seen || s_axis_tuser;
    assign w_row      = s_axis_tuser ? '0 : r_row;
    assign w_col      = s_axis_tuser ? '0 : r_col;
    assign w_max_base = s_axis_tuser ? 8'd0 : r_max;
`else
    assign w_active   = 1'b1;
    assign w_row      = r_row;
    assign w_col      = r_col;
    assign w_max_base = r_max;
`endif

    assign w_rrel    = int'(w_row) - int'(r_row0);
    assign w_crel    = int'(w_col) - int'(r_col0);
    assign w_in_win  = (w_rrel >= 0) && (w_rrel < OUT_ROWS) &&
                       (w_crel >= 0) && (w_crel < OUT_COLS);
    assign w_wr_addr = c_AW'(w_rrel * OUT_COLS + w_crel);
    assign w_wr_en   = w_accept && w_active && w_in_win;

    assign w_col_wrap = (w_col == c_CW'(IN_COLS - 1));
    assign w_last_in  = w_col_wrap && (w_row == c_RW'(IN_ROWS - 1));
    assign w_next_col = w_col_wrap ? '0 : w_col + c_CW'(1);
    assign w_next_row = w_col_wrap ? w_row + c_RW'(1) : w_row;
    assign w_next_max = (w_in_win && (s_axis_tdata > w_max_base)) ? s_axis_tdata
                                                                  : w_max_base;

    // Keep the window fully inside the frame.
    assign w_row0_clamp = (int'(crop_row_start) > (IN_ROWS - OUT_ROWS)) ?
                          c_RW'(IN_ROWS - OUT_ROWS) : crop_row_start;
    assign w_col0_clamp = (int'(crop_col_start) > (IN_COLS - OUT_COLS)) ?
                          c_CW'(IN_COLS - OUT_COLS) : crop_col_start;

    // ------------------------------------------------------------------
    // Read-side flow control. The P stage refills in the same cycle that it
    // hands its pixel to M, so an unstalled sink sees one beat per cycle.
    // Reads begin in PUBLISH so the first beat is on the port two cycles
    // after PUBLISH.
    // ------------------------------------------------------------------
    logic w_m_load;
    logic w_p_free;
    logic w_rd_en;
    logic w_rd_last;
    logic w_m_fire;

    assign w_m_fire  = r_m_valid && m_axis_tready;
    assign w_m_load  = r_p_valid && (!r_m_valid || m_axis_tready);
    assign w_p_free  = !r_p_valid || w_m_load;
    assign w_rd_en   = ((r_state == S_PUBLISH) || (r_state == S_STREAM)) &&
                       r_rd_more && w_p_free;
    assign w_rd_last = (int'(r_rd_addr) == (c_DEPTH - 1));

    // Crop buffer: synchronous write during capture, 1-cycle registered read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= s_axis_tdata;
        end
        if (w_rd_en) begin
            r_q <= r_mem[r_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_idle        <= 1'b1;
            r_done        <= 1'b0;
            r_s_ready     <= 1'b0;
            r_row         <= '0;
            r_col         <= '0;
            r_row0        <= '0;
            r_col0        <= '0;
            r_max         <= 8'd0;
            r_denom       <= 8'd0;
            r_denom_valid <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_more     <= 1'b0;
            r_p_valid     <= 1'b0;
            r_p_last      <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_data      <= 8'd0;
`ifdef CROP_NORM_WRITER_SOF_EN
            r_sof_seen    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_row0    <= w_row0_clamp;
                        r_col0    <= w_col0_clamp;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_max     <= 8'd0;
                        r_rd_addr <= '0;
                        r_rd_more <= 1'b1;
                        r_ready   <= 1'b0;
                        r_idle    <= 1'b0;
                        r_s_ready <= 1'b1;
`ifdef CROP_NORM_WRITER_SOF_EN
                        r_sof_seen <= 1'b0;
`endif
                        r_state   <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    if (w_accept && w_active) begin
                        r_row <= w_next_row;
                        r_col <= w_next_col;
                        r_max <= w_next_max;
`ifdef CROP_NORM_WRITER_SOF_EN
                        r_sof_seen <= 1'b1;
`endif
                        if (w_last_in) begin
                            r_s_ready <= 1'b0;
                            r_state   <= S_PUBLISH;
                        end
                    end
                end

                S_PUBLISH: begin
                    r_denom       <= (r_max == 8'd0) ? 8'd1 : r_max;
                    r_denom_valid <= 1'b1;
                    r_state       <= S_STREAM;
                end

                S_STREAM: begin
                    if (w_m_fire && r_m_last) begin
                        r_denom_valid <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_ready <= 1'b1;
                    r_idle  <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // P stage: a new read fills it, a transfer to M empties it.
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + c_AW'(1);
                r_rd_more <= !w_rd_last;
                r_p_valid <= 1'b1;
                r_p_last  <= w_rd_last;
            end else if (w_m_load) begin
                r_p_valid <= 1'b0;
            end

            // M stage: only changes when empty or being consumed.
            if (w_m_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_q;
                r_m_last  <= r_p_last;
            end else if (w_m_fire) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign ap_ready                = r_ready;
    assign ap_idle                 = r_idle;
    assign ap_done                 = r_done;
    assign s_axis_tready           = r_s_ready;
    assign norm_denominator        = r_denom;
    assign norm_denominator_tvalid = r_denom_valid;
    assign m_axis_tvalid           = r_m_valid;
    assign m_axis_tdata            = r_m_data;
    assign m_axis_tlast            = r_m_last;

endmodule

`default_nettype wire

// File: tb/tb_crop_norm_writer.sv
// ============================================================================
// Module   : tb_crop_norm_writer
// Purpose  : Directed scoreboard bench for crop_norm_writer on a 4x4 frame
//            with a 2x2 window. Expected crop beats are pushed when the frame
//            is driven and popped as the DUT emits them.
// Options  : CROP_NORM_WRITER_SOF_EN - exercises the start-of-frame input
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crop_norm_writer;

    localparam int c_IR = 4;
    localparam int c_IC = 4;
    localparam int c_OR = 2;
    localparam int c_OC = 2;
    localparam int c_N  = c_IR * c_IC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ap_start = 1'b0;
    logic       ap_ready;
    logic       ap_idle;
    logic       ap_done;
    logic [1:0] crop_row_start = 2'd0;
    logic [1:0] crop_col_start = 2'd0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] s_axis_tdata = 8'd0;
`ifdef CROP_NORM_WRITER_SOF_EN
    logic       s_axis_tuser = 1'b0;
`endif
    logic [7:0] norm_denominator;
    logic       norm_denominator_tvalid;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tlast;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [8:0] q[$];            // {tlast, tdata}
    logic [7:0] frame [c_N];
    logic [7:0] exp_denom;

    always #5 clk = ~clk;

    crop_norm_writer #(
        .IN_ROWS (c_IR),
        .IN_COLS (c_IC),
        .OUT_ROWS(c_OR),
        .OUT_COLS(c_OC)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ap_start               (ap_start),
        .ap_ready               (ap_ready),
        .ap_idle                (ap_idle),
        .ap_done                (ap_done),
        .crop_row_start         (crop_row_start),
        .crop_col_start         (crop_col_start),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tready          (s_axis_tready),
        .s_axis_tdata           (s_axis_tdata),
`ifdef CROP_NORM_WRITER_SOF_EN
        .s_axis_tuser           (s_axis_tuser),
`endif
        .norm_denominator       (norm_denominator),
        .norm_denominator_tvalid(norm_denominator_tvalid),
        .m_axis_tvalid          (m_axis_tvalid),
        .m_axis_tready          (m_axis_tready),
        .m_axis_tdata           (m_axis_tdata),
        .m_axis_tlast           (m_axis_tlast)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ap_ready"},  32'(ap_ready), 1);
        check({tag, "_ap_idle"},   32'(ap_idle), 1);
        check({tag, "_ap_done"},   32'(ap_done), 0);
        check({tag, "_s_tready"},  32'(s_axis_tready), 0);
        check({tag, "_m_tvalid"},  32'(m_axis_tvalid), 0);
        check({tag, "_m_tlast"},   32'(m_axis_tlast), 0);
        check({tag, "_m_tdata"},   32'(m_axis_tdata), 0);
        check({tag, "_denom"},     32'(norm_denominator), 0);
        check({tag, "_denom_vld"}, 32'(norm_denominator_tvalid), 0);
    endtask

    // Reference crop: clamp origin, push window pixels in raster order.
    task automatic build_expect(input int r, input int c);
        int         r0;
        int         c0;
        logic [7:0] mx;
        logic [7:0] p;
        r0 = (r > c_IR - c_OR) ? c_IR - c_OR : r;
        c0 = (c > c_IC - c_OC) ? c_IC - c_OC : c;
        mx = 8'd0;
        for (int rr = 0; rr < c_OR; rr++) begin
            for (int cc = 0; cc < c_OC; cc++) begin
                p = frame[(r0 + rr) * c_IC + c0 + cc];
                if (p > mx) mx = p;
                q.push_back({1'((rr == c_OR - 1) && (cc == c_OC - 1)), p});
            end
        end
        exp_denom = (mx == 8'd0) ? 8'd1 : mx;
    endtask

    task automatic do_start(input int r, input int c);
        @(negedge clk);
        crop_row_start = 2'(r);
        crop_col_start = 2'(c);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        check("start_s_tready", 32'(s_axis_tready), 1);
        check("start_ap_ready", 32'(ap_ready), 0);
    endtask

    // Called at a negedge; returns at the negedge following the last accept.
    task automatic send_frame(input int junk);
        int   i;
        int   budget;
        logic rdy;
        i = -junk;
        budget = 0;
        while (i < c_N && budget < 1000) begin
            s_axis_tvalid = (budget % 5 != 3);   // occasional input bubble
            if (i < 0) s_axis_tdata = 8'hA5;
            else       s_axis_tdata = frame[i];
`ifdef CROP_NORM_WRITER_SOF_EN
            s_axis_tuser = (i == 0);
`endif
            rdy = s_axis_tready && s_axis_tvalid;
            @(negedge clk);
            budget++;
            if (rdy) i++;
        end
        s_axis_tvalid = 1'b0;
`ifdef CROP_NORM_WRITER_SOF_EN
        s_axis_tuser = 1'b0;
`endif
        check("frame_accepted", 32'(i), 32'(c_N));
    endtask

    task automatic collect(input int max_beats, input logic [3:0] pat);
        int         got;
        int         k;
        logic       held;
        logic [8:0] hv;
        logic [8:0] e;
        got  = 0;
        k    = 0;
        held = 1'b0;
        hv   = 9'd0;
        while (got < max_beats && k < 200) begin
            if (held)
                check("stall_stable", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                      {22'd0, 1'b1, hv});
            check("denom_hold", 32'(norm_denominator_tvalid), 1);
            m_axis_tready = pat[k % 4];
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() > 0) e = q.pop_front();
                else              e = 9'h1FF;
                check("beat", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, e});
                got++;
                held = 1'b0;
            end else begin
                held = m_axis_tvalid;
                hv   = {m_axis_tlast, m_axis_tdata};
            end
            @(negedge clk);
            k++;
        end
        m_axis_tready = 1'b0;
        check("beat_count", 32'(got), 32'(max_beats));
    endtask

    task automatic run_frame(input int r, input int c, input int junk, input logic [3:0] pat);
        build_expect(r, c);
        do_start(r, c);
        send_frame(junk);
        check("publish_s_tready", 32'(s_axis_tready), 0);
        check("publish_denom_vld", 32'(norm_denominator_tvalid), 0);
        @(negedge clk);
        check("denom_valid", 32'(norm_denominator_tvalid), 1);
        check("denom_value", 32'(norm_denominator), 32'(exp_denom));
        @(negedge clk);
        check("first_beat_latency", 32'(m_axis_tvalid), 1);
        collect(c_OR * c_OC, pat);
        check("done_pulse", 32'(ap_done), 1);
        check("done_no_extra_beat", 32'(m_axis_tvalid), 0);
        check("done_denom_drop", 32'(norm_denominator_tvalid), 0);
        check("done_ap_ready_low", 32'(ap_ready), 0);
        @(negedge clk);
        check("done_single", 32'(ap_done), 0);
        check("idle_ap_ready", 32'(ap_ready), 1);
        check("idle_ap_idle", 32'(ap_idle), 1);
        check("scoreboard_empty", 32'(q.size()), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // Basic crop: raster-index pixels, origin (1,1) -> 5,6,9,10
        for (int i = 0; i < c_N; i++) frame[i] = 8'(i);
        run_frame(1, 1, 0, 4'b1111);

        // Backpressure with ready pattern 1,0,0,1
        run_frame(1, 1, 0, 4'b1001);

        // Zero frame -> denominator forced to 1
        for (int i = 0; i < c_N; i++) frame[i] = 8'd0;
        run_frame(1, 1, 0, 4'b1111);

        // Origin clamp (3,3) -> (2,2): 10,11,14,15
        for (int i = 0; i < c_N; i++) frame[i] = 8'(i);
        run_frame(3, 3, 0, 4'b1111);

        // Random pixels, top-right window, with backpressure
        for (int i = 0; i < c_N; i++) frame[i] = 8'($urandom_range(0, 255));
        run_frame(0, 2, 0, 4'b1001);

        // Reset after two output beats
        for (int i = 0; i < c_N; i++) frame[i] = 8'(i);
        build_expect(1, 1);
        do_start(1, 1);
        send_frame(0);
        repeat (2) @(negedge clk);
        check("rst_first_beat", 32'(m_axis_tvalid), 1);
        collect(2, 4'b1111);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("stream_reset");
        reset = 1'b0;
        q.delete();
        @(negedge clk);
        run_frame(1, 1, 0, 4'b1111);

`ifdef CROP_NORM_WRITER_SOF_EN
        // Junk beats before start of frame are discarded
        run_frame(1, 1, 3, 4'b1111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crop_norm_writer.md
# crop_norm_writer

Upstream producer for the normalization stage: accepts one full camera frame as an 8-bit AXI-Stream, captures an OUT_ROWS×OUT_COLS crop window into an internal buffer, and tracks the window's maximum pixel. It then publishes that maximum as the normalization denominator and streams the buffered crop out on an AXI-Stream master into the normalizer's slave port. It is sequenced by the same ap_start/ap_ready/ap_done handshake as the rest of the crop/normalize chain.

## Interface
- IN_ROWS, 32: input frame rows.
- IN_COLS, 32: input frame columns.
- OUT_ROWS, 10: crop window rows; OUT_ROWS ≤ IN_ROWS.
- OUT_COLS, 10: crop window columns; OUT_COLS ≤ IN_COLS.

- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_ready  out  1  high in IDLE only.
- ap_idle  out  1  high in IDLE only.
- ap_done  out  1  one-cycle pulse after the last output beat.
- crop_row_start  in  $clog2(IN_ROWS)  window top row; latched on start.
- crop_col_start  in  $clog2(IN_COLS)  window left column; latched on start.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  8  input pixel, raster order.
- norm_denominator  out  8  window maximum; forced to 1 if the maximum is 0.
- norm_denominator_tvalid  out  1  denominator valid.
- m_axis_tvalid  out  1  cropped pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  8  cropped pixel, raster order.
- m_axis_tlast  out  1  high on the final (OUT_ROWS*OUT_COLS-th) beat.

## Operation
- FSM states: IDLE, CAPTURE, PUBLISH, STREAM, DONE.
- IDLE
  - On ap_start=1: latch the crop origin, clear the row/column counters and the running max, go to CAPTURE.
  - Latched origin is clamped: row = min(crop_row_start, IN_ROWS-OUT_ROWS); column likewise with IN_COLS-OUT_COLS.
- CAPTURE
  - s_axis_tready=1.
  - Each accepted beat advances the column counter; at IN_COLS-1 the column wraps to 0 and the row increments.
  - A beat inside the window is written to buffer address (r-row0)*OUT_COLS+(c-col0), and max is updated to max(max, tdata).
  - Beats outside the window are consumed and discarded.
  - The accepted beat at (IN_ROWS-1, IN_COLS-1) moves the FSM to PUBLISH.
- PUBLISH (1 cycle)
  - norm_denominator is registered as (max==0 ? 1 : max).
  - norm_denominator_tvalid rises and stays high through STREAM.
- STREAM
  - Buffer has 1-cycle synchronous read; a registered output stage feeds m_axis.
  - Handshake rules:
    - tdata and tlast stay stable while tvalid && !tready.
    - tvalid never drops before a handshake.
    - Back-to-back handshakes sustain 1 beat/cycle (next address is prefetched).
  - The handshake with tlast=1 moves the FSM to DONE.
- DONE (1 cycle)
  - ap_done=1; norm_denominator_tvalid drops; return to IDLE.
- Buffer depth is OUT_ROWS*OUT_COLS × 8 bits; counters are sized with $clog2.
- ap_start outside IDLE is ignored.

## Timing
- Reset values:
  - ap_ready=1, ap_idle=1.
  - ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
  - m_axis_tdata=0, norm_denominator=0, norm_denominator_tvalid=0.
  - FSM in IDLE.
- Reset in any state returns to these values on the next edge. A partial frame is abandoned; buffer contents are don't-care.
- ap_start=1 in IDLE at cycle t: s_axis_tready=1 at t+1.
- Last input handshake at t: PUBLISH at t+1; norm_denominator_tvalid=1 at t+2; first m_axis_tvalid=1 no later than t+3.
- Final output handshake at t: ap_done=1 at t+1, ap_ready=1 at t+2.
- Total input beats consumed per start = IN_ROWS*IN_COLS exactly. Total output beats = OUT_ROWS*OUT_COLS exactly.

## Configuration
- CROP_NORM_WRITER_SOF_EN defined:
  - Adds input s_axis_tuser (1 bit, start of frame).
  - CAPTURE discards beats until one with tuser=1; that beat is pixel (0,0).
  - A tuser=1 beat mid-frame restarts the counters and max, and is treated as pixel (0,0).
- Undefined: no tuser port; the first beat accepted after entering CAPTURE is pixel (0,0).

## Test plan
- Basic crop:
  - Stimulus: IN 4×4, OUT 2×2, origin (1,1), pixel value = raster index 0..15, m_axis_tready=1.
  - Response: outputs 5,6,9,10; tlast on 10; norm_denominator=10; ap_done pulses once.
- Backpressure:
  - Stimulus: as basic crop, with m_axis_tready toggling 1,0,0,1.
  - Response: same sequence with no duplicated or dropped beats; tdata stable during stalls.
- Zero frame:
  - Stimulus: all pixels 0.
  - Response: norm_denominator=1; outputs 0,0,0,0.
- Origin clamp:
  - Stimulus: origin (3,3) on 4×4/2×2.
  - Response: outputs 10,11,14,15; denominator 15.
- Reset in STREAM:
  - Stimulus: assert reset after 2 output beats.
  - Response: next cycle all outputs at reset values. A new ap_start then yields a correct full crop.
- SOF (with CROP_NORM_WRITER_SOF_EN):
  - Stimulus: 3 junk beats, then a tuser=1 beat, then the basic-crop frame.
  - Response: identical output to the basic-crop case.
